// File: rtl/pid_pwm_out_pkg.sv
// -----------------------------------------------------------------------------
// pid_pkg
// Shared constants and types for the PID output stage.
//   PID_D_WIDTH    : default width of the signed PID controller output word
//   PID_CNT_WIDTH  : default width of the PWM period counter / duty count
//   PID_DUTY_SHIFT : default arithmetic right shift from PID word to duty count
//   PID_DEAD_WIDTH : default width of the dead-time setting
//   pid_word_t     : signed PID word at the default width
//   pwm_cnt_t      : PWM counter / duty value at the default width
// -----------------------------------------------------------------------------
package pid_pkg;

   localparam int PID_D_WIDTH    = 18;
   localparam int PID_CNT_WIDTH  = 10;
   localparam int PID_DUTY_SHIFT = 8;
   localparam int PID_DEAD_WIDTH = 4;

   typedef logic signed [PID_D_WIDTH-1:0] pid_word_t;
   typedef logic [PID_CNT_WIDTH-1:0]      pwm_cnt_t;

endpackage

// File: rtl/pid_pwm_out_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
// Turns the raw PWM level into a complementary gate pair with dead time.
// On every raw edge both gates drop for `deadtime` cycles before the side
// matching raw asserts; another raw edge inside the gap restarts it.
// deadtime = 0 gives plain one-cycle-registered outputs.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   enable       : 0 forces both gates low on the next edge
//   raw          : raw PWM level (already qualified by enable)
//   deadtime     : dead-time length in cycles
//   pwm_hi/lo    : registered high-/low-side gate drives
// -----------------------------------------------------------------------------
module pwm_deadtime
   import pid_pkg::*;
#(
   parameter int DEAD_WIDTH = PID_DEAD_WIDTH
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  raw,
   input  logic [DEAD_WIDTH-1:0] deadtime,
   output logic                  pwm_hi,
   output logic                  pwm_lo
);

   logic                  raw_d_r;
   logic [DEAD_WIDTH-1:0] dead_cnt_r;
   logic [DEAD_WIDTH-1:0] dead_cnt_next_s;
   logic                  hi_next_s;
   logic                  lo_next_s;
   logic                  edge_s;

   assign edge_s = raw ^ raw_d_r;

   // Next gate levels and dead counter; the counter holds the remaining gap
   // cycles after the one that starts on the edge itself.
   always_comb begin
      hi_next_s       = raw;
      lo_next_s       = enable & ~raw;
      dead_cnt_next_s = dead_cnt_r;
      if (!enable) begin
         hi_next_s       = 1'b0;
         lo_next_s       = 1'b0;
         dead_cnt_next_s = {DEAD_WIDTH{1'b0}};
      end else if (edge_s && (deadtime != {DEAD_WIDTH{1'b0}})) begin
         hi_next_s       = 1'b0;
         lo_next_s       = 1'b0;
         dead_cnt_next_s = deadtime - DEAD_WIDTH'(1'b1);
      end else if (!edge_s && (dead_cnt_r != {DEAD_WIDTH{1'b0}})) begin
         hi_next_s       = 1'b0;
         lo_next_s       = 1'b0;
         dead_cnt_next_s = dead_cnt_r - DEAD_WIDTH'(1'b1);
      end else begin
         dead_cnt_next_s = {DEAD_WIDTH{1'b0}};
      end
   end

   // Gate registers, raw edge history and dead counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         raw_d_r    <= 1'b0;
         dead_cnt_r <= {DEAD_WIDTH{1'b0}};
         pwm_hi     <= 1'b0;
         pwm_lo     <= 1'b0;
      end else begin
         raw_d_r    <= raw;
         dead_cnt_r <= dead_cnt_next_s;
         pwm_hi     <= hi_next_s;
         pwm_lo     <= lo_next_s;
      end
   end

endmodule

// File: rtl/pid_pwm_out.sv
// -----------------------------------------------------------------------------
// pid_pwm_out
// Converts the signed PID output into a fixed-frequency complementary PWM pair.
// The PID word is shifted and clamped to a duty count, held in a shadow
// register and applied only at period boundaries.  period_start pulses once
// per period and is meant to drive the PID iterate enable.
// Optional dead time: define PID_PWM_DEADTIME_EN to instantiate pwm_deadtime;
// otherwise the deadtime port is ignored and outputs are raw delayed 1 cycle.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   enable        : 1 = run; 0 = gates low, counter held at 0
//   period        : counter max, PWM period = period+1 cycles (boundary-loaded)
//   deadtime      : dead-time cycles (used only with PID_PWM_DEADTIME_EN)
//   pid_out       : signed controller output, captured when pid_valid = 1
//   pid_valid     : capture strobe
//   pwm_hi/pwm_lo : registered complementary gate drives
//   period_start  : high while the counter is 0 and enable = 1
//   duty_active   : duty count applied to the running period
//   sat_flag      : last captured pid_out was clamped
// -----------------------------------------------------------------------------
module pid_pwm_out
   import pid_pkg::*;
#(
   parameter int D_WIDTH    = PID_D_WIDTH,
   parameter int CNT_WIDTH  = PID_CNT_WIDTH,
   parameter int DUTY_SHIFT = PID_DUTY_SHIFT,
   parameter int DEAD_WIDTH = PID_DEAD_WIDTH
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [CNT_WIDTH-1:0]      period,
   input  logic [DEAD_WIDTH-1:0]     deadtime,
   input  logic signed [D_WIDTH-1:0] pid_out,
   input  logic                      pid_valid,
   output logic                      pwm_hi,
   output logic                      pwm_lo,
   output logic                      period_start,
   output logic [CNT_WIDTH-1:0]      duty_active,
   output logic                      sat_flag
);

   // One extra bit so the shifted word and period+1 compare without wrapping.
   localparam int CALC_W = D_WIDTH + 1;
   localparam int LIM_W  = CNT_WIDTH + 1;

   logic [CNT_WIDTH-1:0]     cnt_r;
   logic [CNT_WIDTH-1:0]     cnt_next_s;
   logic [CNT_WIDTH-1:0]     period_active_r;
   logic [CNT_WIDTH-1:0]     duty_shadow_r;
   logic                     en_d_r;
   logic                     first_s;
   logic                     wrap_s;
   logic                     load_s;
   logic                     raw_s;

   logic signed [CALC_W-1:0] ext_s;
   logic signed [CALC_W-1:0] shifted_s;
   logic [LIM_W-1:0]         lim_u_s;
   logic signed [CALC_W-1:0] limit_s;
   logic [CNT_WIDTH-1:0]     duty_max_s;
   logic [CNT_WIDTH-1:0]     conv_duty_s;
   logic                     conv_sat_s;

   assign ext_s     = {pid_out[D_WIDTH-1], pid_out};
   assign shifted_s = ext_s >>> DUTY_SHIFT;
   assign lim_u_s   = {1'b0, period_active_r} + LIM_W'(1'b1);
   assign limit_s   = signed'({{(CALC_W-LIM_W){1'b0}}, lim_u_s});
   // period+1 does not fit the duty field when period is all ones; the largest
   // representable duty (high for all but the last cycle) is used instead.
   assign duty_max_s = lim_u_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : lim_u_s[CNT_WIDTH-1:0];

   // Shift-and-clamp of the PID word to a duty count.
   always_comb begin
      conv_duty_s = {CNT_WIDTH{1'b0}};
      conv_sat_s  = 1'b0;
      if (shifted_s[CALC_W-1]) begin
         conv_duty_s = {CNT_WIDTH{1'b0}};
         conv_sat_s  = 1'b1;
      end else if (shifted_s >= limit_s) begin
         conv_duty_s = duty_max_s;
         conv_sat_s  = (shifted_s > limit_s);
      end else begin
         conv_duty_s = shifted_s[CNT_WIDTH-1:0];
         conv_sat_s  = 1'b0;
      end
   end

   // Counter sequencing; the first enabled cycle acts as a boundary so the
   // freshly loaded period already governs the counter's wrap.
   always_comb begin
      first_s    = enable & ~en_d_r;
      wrap_s     = first_s ? (cnt_r == period) : (cnt_r == period_active_r);
      load_s     = enable & (first_s | wrap_s);
      cnt_next_s = {CNT_WIDTH{1'b0}};
      if (!enable) begin
         cnt_next_s = {CNT_WIDTH{1'b0}};
      end else if (wrap_s) begin
         cnt_next_s = {CNT_WIDTH{1'b0}};
      end else begin
         cnt_next_s = cnt_r + CNT_WIDTH'(1'b1);
      end
   end

   assign period_start = enable & (cnt_r == {CNT_WIDTH{1'b0}});
   assign raw_s        = enable & (cnt_r < duty_active);

   // Counter, capture and boundary-load registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r           <= {CNT_WIDTH{1'b0}};
         en_d_r          <= 1'b0;
         period_active_r <= {CNT_WIDTH{1'b0}};
         duty_shadow_r   <= {CNT_WIDTH{1'b0}};
         duty_active     <= {CNT_WIDTH{1'b0}};
         sat_flag        <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         en_d_r <= enable;
         if (pid_valid) begin
            duty_shadow_r <= conv_duty_s;
            sat_flag      <= conv_sat_s;
         end
         if (load_s) begin
            period_active_r <= period;
            // A capture on the boundary cycle bypasses the shadow.
            duty_active     <= pid_valid ? conv_duty_s : duty_shadow_r;
         end
      end
   end

`ifdef PID_PWM_DEADTIME_EN
   pwm_deadtime #(
      .DEAD_WIDTH (DEAD_WIDTH)
   ) u_deadtime (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .raw      (raw_s),
      .deadtime (deadtime),
      .pwm_hi   (pwm_hi),
      .pwm_lo   (pwm_lo)
   );
`else
   logic deadtime_unused_s;
   assign deadtime_unused_s = ^deadtime;

   // Plain registered gate pair, one cycle behind raw.
   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_hi <= 1'b0;
         pwm_lo <= 1'b0;
      end else begin
         pwm_hi <= raw_s;
         pwm_lo <= enable & ~raw_s;
      end
   end
`endif

endmodule
